// File: rtl/otter_pkg.sv
// Shared types and constants for the OTTER ID/EX boundary: operand selects,
// ALU function codes and the registered ID/EX record with its bubble value.
package otter_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    SRCA_RS1  = 2'd0,
    SRCA_PC   = 2'd1,
    SRCA_IMM  = 2'd2,
    SRCA_ZERO = 2'd3
  } srca_sel_t;

  typedef enum logic [1:0] {
    SRCB_RS2   = 2'd0,
    SRCB_IMM   = 2'd1,
    SRCB_FOUR  = 2'd2,
    SRCB_ZERO  = 2'd3
  } srcb_sel_t;

  // ALU function codes are {func7[5], func3}
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_LUI  = 4'b1001;

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [REG_AW-1:0] rs1_addr;
    logic [REG_AW-1:0] rs2_addr;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    srca_sel_t         srca_sel;
    srcb_sel_t         srcb_sel;
    logic [3:0]        alu_fun;
    logic [REG_AW-1:0] rd_addr;
    logic              reg_we;
    logic              mem_re;
    logic              mem_we;
  } id_ex_t;

  // All-zero record: no writes, rs addresses x0 so nothing forwards into it
  localparam id_ex_t ID_EX_BUBBLE = '0;

  function automatic logic reg_match(input logic              we,
                                     input logic [REG_AW-1:0] rd,
                                     input logic [REG_AW-1:0] rs);
    return we && (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/otter_fwd_mux.sv
// Operand forwarding for one source register: MEM result beats WB result,
// which beats the registered read data. x0 never takes a forwarded value.
module otter_fwd_mux
  import otter_pkg::*;
(
  input  logic [REG_AW-1:0] i_src_addr,
  input  logic [XLEN-1:0]   i_reg_data,
  input  logic [REG_AW-1:0] i_mem_rd_addr,
  input  logic              i_mem_reg_we,
  input  logic [XLEN-1:0]   i_mem_data,
  input  logic [REG_AW-1:0] i_wb_rd_addr,
  input  logic              i_wb_reg_we,
  input  logic [XLEN-1:0]   i_wb_data,
  output logic [XLEN-1:0]   o_data
);

  logic w_mem_hit;
  logic w_wb_hit;

  assign w_mem_hit = reg_match(i_mem_reg_we, i_mem_rd_addr, i_src_addr);
  assign w_wb_hit  = reg_match(i_wb_reg_we, i_wb_rd_addr, i_src_addr);

  always_comb begin
    o_data = i_reg_data;
    if (w_mem_hit) begin
      o_data = i_mem_data;
    end else if (w_wb_hit) begin
      o_data = i_wb_data;
    end
  end

endmodule

// File: rtl/otter_id_ex_stage.sv
// OTTER ID/EX pipeline register with load-use bubble insertion, WB capture
// bypass, MEM/WB operand forwarding and ALU operand selection.
module otter_id_ex_stage
  import otter_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        ID_VALID,
  input  logic [31:0] ID_PC,
  input  logic [31:0] ID_RS1_DATA,
  input  logic [31:0] ID_RS2_DATA,
  input  logic [4:0]  ID_RS1_ADDR,
  input  logic [4:0]  ID_RS2_ADDR,
  input  logic [4:0]  ID_RD_ADDR,
  input  logic        ID_RS1_USED,
  input  logic        ID_RS2_USED,
  input  logic [31:0] ID_IMM,
  input  logic [1:0]  ID_SRCA_SEL,
  input  logic [1:0]  ID_SRCB_SEL,
  input  logic [3:0]  ID_ALU_FUN,
  input  logic        ID_REG_WE,
  input  logic        ID_MEM_RE,
  input  logic        ID_MEM_WE,
  input  logic [4:0]  MEM_RD_ADDR,
  input  logic        MEM_REG_WE,
  input  logic [31:0] MEM_FWD_DATA,
  input  logic [4:0]  WB_RD_ADDR,
  input  logic        WB_REG_WE,
  input  logic [31:0] WB_DATA,
  input  logic        STALL,
  input  logic        FLUSH,
  output logic        EX_VALID,
  output logic [31:0] ALU_SRC_A,
  output logic [31:0] ALU_SRC_B,
  output logic [3:0]  ALU_FUN,
  output logic [31:0] EX_PC,
  output logic [4:0]  EX_RD_ADDR,
  output logic        EX_REG_WE,
  output logic        EX_MEM_RE,
  output logic        EX_MEM_WE,
  output logic [31:0] EX_STORE_DATA,
  output logic        LOAD_USE_HAZARD
);

  id_ex_t      r_ex;
  id_ex_t      w_cap;
  logic        w_load_use;
  logic [31:0] w_rs1_fwd;
  logic [31:0] w_rs2_fwd;

  // Hazard looks at the load sitting in EX against what decode wants to read
  assign w_load_use = r_ex.valid && r_ex.mem_re && ID_VALID &&
                      (r_ex.rd_addr != 5'd0) &&
                      (((r_ex.rd_addr == ID_RS1_ADDR) && ID_RS1_USED) ||
                       ((r_ex.rd_addr == ID_RS2_ADDR) && ID_RS2_USED));

  always_comb begin
    w_cap          = ID_EX_BUBBLE;
    w_cap.valid    = 1'b1;
    w_cap.pc       = ID_PC;
    w_cap.rs1_addr = ID_RS1_ADDR;
    w_cap.rs2_addr = ID_RS2_ADDR;
    w_cap.rs1_data = reg_match(WB_REG_WE, WB_RD_ADDR, ID_RS1_ADDR) ? WB_DATA : ID_RS1_DATA;
    w_cap.rs2_data = reg_match(WB_REG_WE, WB_RD_ADDR, ID_RS2_ADDR) ? WB_DATA : ID_RS2_DATA;
    w_cap.imm      = ID_IMM;
    w_cap.srca_sel = srca_sel_t'(ID_SRCA_SEL);
    w_cap.srcb_sel = srcb_sel_t'(ID_SRCB_SEL);
    w_cap.alu_fun  = ID_ALU_FUN;
    w_cap.rd_addr  = ID_RD_ADDR;
    w_cap.reg_we   = ID_REG_WE;
    w_cap.mem_re   = ID_MEM_RE;
    w_cap.mem_we   = ID_MEM_WE;
  end

  // ---- ID -> EX register boundary ----
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_ex <= ID_EX_BUBBLE;
    end else if (FLUSH) begin
      r_ex <= ID_EX_BUBBLE;
    end else if (STALL) begin
      // Held operands still pick up a result retiring through WB meanwhile
      if (reg_match(WB_REG_WE, WB_RD_ADDR, r_ex.rs1_addr)) begin
        r_ex.rs1_data <= WB_DATA;
      end
      if (reg_match(WB_REG_WE, WB_RD_ADDR, r_ex.rs2_addr)) begin
        r_ex.rs2_data <= WB_DATA;
      end
    end else if (w_load_use || !ID_VALID) begin
      r_ex <= ID_EX_BUBBLE;
    end else begin
      r_ex <= w_cap;
    end
  end

  // ---- EX: forwarding and operand select (combinational) ----
  otter_fwd_mux u_fwd_rs1 (
    .i_src_addr    (r_ex.rs1_addr),
    .i_reg_data    (r_ex.rs1_data),
    .i_mem_rd_addr (MEM_RD_ADDR),
    .i_mem_reg_we  (MEM_REG_WE),
    .i_mem_data    (MEM_FWD_DATA),
    .i_wb_rd_addr  (WB_RD_ADDR),
    .i_wb_reg_we   (WB_REG_WE),
    .i_wb_data     (WB_DATA),
    .o_data        (w_rs1_fwd)
  );

  otter_fwd_mux u_fwd_rs2 (
    .i_src_addr    (r_ex.rs2_addr),
    .i_reg_data    (r_ex.rs2_data),
    .i_mem_rd_addr (MEM_RD_ADDR),
    .i_mem_reg_we  (MEM_REG_WE),
    .i_mem_data    (MEM_FWD_DATA),
    .i_wb_rd_addr  (WB_RD_ADDR),
    .i_wb_reg_we   (WB_REG_WE),
    .i_wb_data     (WB_DATA),
    .o_data        (w_rs2_fwd)
  );

  always_comb begin
    ALU_SRC_A = 32'd0;
    unique case (r_ex.srca_sel)
      SRCA_RS1:  ALU_SRC_A = w_rs1_fwd;
      SRCA_PC:   ALU_SRC_A = r_ex.pc;
      SRCA_IMM:  ALU_SRC_A = r_ex.imm;
      SRCA_ZERO: ALU_SRC_A = 32'd0;
      default:   ALU_SRC_A = 32'd0;
    endcase
  end

  always_comb begin
    ALU_SRC_B = 32'd0;
    unique case (r_ex.srcb_sel)
      SRCB_RS2:  ALU_SRC_B = w_rs2_fwd;
      SRCB_IMM:  ALU_SRC_B = r_ex.imm;
      SRCB_FOUR: ALU_SRC_B = 32'd4;
      SRCB_ZERO: ALU_SRC_B = 32'd0;
      default:   ALU_SRC_B = 32'd0;
    endcase
  end

  assign EX_VALID        = r_ex.valid;
  assign ALU_FUN         = r_ex.alu_fun;
  assign EX_PC           = r_ex.pc;
  assign EX_RD_ADDR      = r_ex.rd_addr;
  assign EX_REG_WE       = r_ex.reg_we;
  assign EX_MEM_RE       = r_ex.mem_re;
  assign EX_MEM_WE       = r_ex.mem_we;
  assign EX_STORE_DATA   = w_rs2_fwd;
  assign LOAD_USE_HAZARD = w_load_use;

endmodule

// File: tb/tb_otter_id_ex_stage.sv
// Directed bench for otter_id_ex_stage: reset, capture, forwarding priority,
// load-use bubble, stall refresh, flush and operand selects.
module tb_otter_id_ex_stage;
  import otter_pkg::*;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        ID_VALID;
  logic [31:0] ID_PC, ID_RS1_DATA, ID_RS2_DATA, ID_IMM;
  logic [4:0]  ID_RS1_ADDR, ID_RS2_ADDR, ID_RD_ADDR;
  logic        ID_RS1_USED, ID_RS2_USED;
  logic [1:0]  ID_SRCA_SEL, ID_SRCB_SEL;
  logic [3:0]  ID_ALU_FUN;
  logic        ID_REG_WE, ID_MEM_RE, ID_MEM_WE;
  logic [4:0]  MEM_RD_ADDR, WB_RD_ADDR;
  logic        MEM_REG_WE, WB_REG_WE;
  logic [31:0] MEM_FWD_DATA, WB_DATA;
  logic        STALL, FLUSH;
  logic        EX_VALID;
  logic [31:0] ALU_SRC_A, ALU_SRC_B, EX_PC, EX_STORE_DATA;
  logic [3:0]  ALU_FUN;
  logic [4:0]  EX_RD_ADDR;
  logic        EX_REG_WE, EX_MEM_RE, EX_MEM_WE, LOAD_USE_HAZARD;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  otter_id_ex_stage dut (
    .CLK(CLK), .RST_N(RST_N),
    .ID_VALID(ID_VALID), .ID_PC(ID_PC),
    .ID_RS1_DATA(ID_RS1_DATA), .ID_RS2_DATA(ID_RS2_DATA),
    .ID_RS1_ADDR(ID_RS1_ADDR), .ID_RS2_ADDR(ID_RS2_ADDR), .ID_RD_ADDR(ID_RD_ADDR),
    .ID_RS1_USED(ID_RS1_USED), .ID_RS2_USED(ID_RS2_USED),
    .ID_IMM(ID_IMM), .ID_SRCA_SEL(ID_SRCA_SEL), .ID_SRCB_SEL(ID_SRCB_SEL),
    .ID_ALU_FUN(ID_ALU_FUN), .ID_REG_WE(ID_REG_WE), .ID_MEM_RE(ID_MEM_RE), .ID_MEM_WE(ID_MEM_WE),
    .MEM_RD_ADDR(MEM_RD_ADDR), .MEM_REG_WE(MEM_REG_WE), .MEM_FWD_DATA(MEM_FWD_DATA),
    .WB_RD_ADDR(WB_RD_ADDR), .WB_REG_WE(WB_REG_WE), .WB_DATA(WB_DATA),
    .STALL(STALL), .FLUSH(FLUSH),
    .EX_VALID(EX_VALID), .ALU_SRC_A(ALU_SRC_A), .ALU_SRC_B(ALU_SRC_B), .ALU_FUN(ALU_FUN),
    .EX_PC(EX_PC), .EX_RD_ADDR(EX_RD_ADDR), .EX_REG_WE(EX_REG_WE),
    .EX_MEM_RE(EX_MEM_RE), .EX_MEM_WE(EX_MEM_WE), .EX_STORE_DATA(EX_STORE_DATA),
    .LOAD_USE_HAZARD(LOAD_USE_HAZARD)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_id();
    ID_VALID = 0; ID_PC = 0; ID_RS1_DATA = 0; ID_RS2_DATA = 0; ID_IMM = 0;
    ID_RS1_ADDR = 0; ID_RS2_ADDR = 0; ID_RD_ADDR = 0;
    ID_RS1_USED = 0; ID_RS2_USED = 0; ID_SRCA_SEL = 0; ID_SRCB_SEL = 0;
    ID_ALU_FUN = 0; ID_REG_WE = 0; ID_MEM_RE = 0; ID_MEM_WE = 0;
  endtask

  task automatic clear_fwd();
    MEM_RD_ADDR = 0; MEM_REG_WE = 0; MEM_FWD_DATA = 0;
    WB_RD_ADDR = 0; WB_REG_WE = 0; WB_DATA = 0;
  endtask

  initial begin
    RST_N = 0; STALL = 0; FLUSH = 0;
    clear_id();
    clear_fwd();
    #2;
    chk("rst_valid", {31'd0, EX_VALID}, 32'd0);
    chk("rst_alu_fun", {28'd0, ALU_FUN}, 32'd0);
    chk("rst_src_a", ALU_SRC_A, 32'd0);
    chk("rst_src_b", ALU_SRC_B, 32'd0);
    chk("rst_luh", {31'd0, LOAD_USE_HAZARD}, 32'd0);

    // Basic capture: A = rs1 (5), B = IMM (7)
    @(negedge CLK);
    RST_N = 1;
    ID_VALID = 1; ID_PC = 32'h100; ID_RS1_ADDR = 5'd1; ID_RS1_DATA = 32'd5;
    ID_SRCA_SEL = 2'd0; ID_SRCB_SEL = 2'd1; ID_IMM = 32'd7; ID_ALU_FUN = ALU_SUB;
    ID_REG_WE = 1; ID_RD_ADDR = 5'd2;
    step();
    chk("cap_src_a", ALU_SRC_A, 32'd5);
    chk("cap_src_b", ALU_SRC_B, 32'd7);
    chk("cap_pc", EX_PC, 32'h100);
    chk("cap_alu_fun", {28'd0, ALU_FUN}, {28'd0, ALU_SUB});
    chk("cap_reg_we", {31'd0, EX_REG_WE}, 32'd1);

    // Asynchronous reset in the middle of a stall
    STALL = 1;
    #2 RST_N = 0;
    #1;
    chk("mid_rst_valid", {31'd0, EX_VALID}, 32'd0);
    chk("mid_rst_alu_fun", {28'd0, ALU_FUN}, 32'd0);
    chk("mid_rst_src_a", ALU_SRC_A, 32'd0);
    chk("mid_rst_src_b", ALU_SRC_B, 32'd0);
    @(negedge CLK);
    RST_N = 1; STALL = 0;
    step();
    chk("post_rst_src_a", ALU_SRC_A, 32'd5);
    chk("post_rst_src_b", ALU_SRC_B, 32'd7);
    chk("post_rst_pc", EX_PC, 32'h100);

    // Forwarding priority on rs1 = x3
    clear_id();
    ID_VALID = 1; ID_RS1_ADDR = 5'd3; ID_RS1_DATA = 32'h11; ID_SRCA_SEL = 2'd0;
    step();
    chk("fwd_none", ALU_SRC_A, 32'h11);
    MEM_RD_ADDR = 5'd3; MEM_REG_WE = 1; MEM_FWD_DATA = 32'hAA;
    WB_RD_ADDR = 5'd3; WB_REG_WE = 1; WB_DATA = 32'hBB;
    #1 chk("fwd_mem_over_wb", ALU_SRC_A, 32'hAA);
    MEM_REG_WE = 0;
    #1 chk("fwd_wb", ALU_SRC_A, 32'hBB);

    // x0 is never forwarded
    clear_fwd();
    ID_RS1_ADDR = 5'd0; ID_RS1_DATA = 32'h22;
    step();
    MEM_RD_ADDR = 5'd0; MEM_REG_WE = 1; MEM_FWD_DATA = 32'hAA;
    WB_RD_ADDR = 5'd0; WB_REG_WE = 1; WB_DATA = 32'hBB;
    #1 chk("fwd_x0", ALU_SRC_A, 32'h22);

    // WB value is taken at capture time instead of stale register-file data
    clear_fwd();
    ID_RS1_ADDR = 5'd4; ID_RS1_DATA = 32'h1;
    WB_RD_ADDR = 5'd4; WB_REG_WE = 1; WB_DATA = 32'h77;
    step();
    clear_fwd();
    #1 chk("cap_bypass", ALU_SRC_A, 32'h77);

    // Load-use: load to x5 in EX, decode reads x5 as rs2
    clear_id();
    ID_VALID = 1; ID_RD_ADDR = 5'd5; ID_MEM_RE = 1; ID_REG_WE = 1;
    step();
    chk("ld_mem_re", {31'd0, EX_MEM_RE}, 32'd1);
    clear_id();
    ID_VALID = 1; ID_RS2_ADDR = 5'd5; ID_RS2_USED = 1; ID_RS2_DATA = 32'h9;
    ID_SRCB_SEL = 2'd0; ID_RD_ADDR = 5'd6; ID_REG_WE = 1;
    #1 chk("luh_set", {31'd0, LOAD_USE_HAZARD}, 32'd1);
    ID_RS2_USED = 0;
    #1 chk("luh_unused", {31'd0, LOAD_USE_HAZARD}, 32'd0);
    ID_RS2_USED = 1;
    step();
    chk("luh_bubble", {31'd0, EX_VALID}, 32'd0);
    chk("luh_clear", {31'd0, LOAD_USE_HAZARD}, 32'd0);
    WB_RD_ADDR = 5'd5; WB_REG_WE = 1; WB_DATA = 32'h55;
    step();
    chk("luh_retry_valid", {31'd0, EX_VALID}, 32'd1);
    chk("luh_wb_operand", ALU_SRC_B, 32'h55);
    clear_fwd();

    // STALL beats the load-use bubble
    clear_id();
    ID_VALID = 1; ID_RD_ADDR = 5'd8; ID_MEM_RE = 1; ID_REG_WE = 1;
    step();
    ID_RS1_ADDR = 5'd8; ID_RS1_USED = 1; ID_MEM_RE = 0; ID_RD_ADDR = 5'd9;
    STALL = 1;
    step();
    chk("stall_over_luh_valid", {31'd0, EX_VALID}, 32'd1);
    chk("stall_over_luh_rd", {27'd0, EX_RD_ADDR}, 32'd8);
    STALL = 0;

    // Stall refresh of rs2 = x7
    clear_id();
    ID_VALID = 1; ID_PC = 32'h200; ID_RS2_ADDR = 5'd7; ID_RS2_DATA = 32'h1; ID_SRCB_SEL = 2'd0;
    step();
    STALL = 1;
    ID_PC = 32'h300; ID_RS2_DATA = 32'hDEAD;
    step();
    WB_RD_ADDR = 5'd7; WB_REG_WE = 1; WB_DATA = 32'h1234;
    step();
    clear_fwd();
    step();
    STALL = 0;
    #1;
    chk("stall_refresh", EX_STORE_DATA, 32'h1234);
    chk("stall_hold_pc", EX_PC, 32'h200);

    // FLUSH beats STALL
    clear_id();
    ID_VALID = 1; ID_REG_WE = 1; ID_MEM_WE = 1; ID_RD_ADDR = 5'd10;
    FLUSH = 1; STALL = 1;
    step();
    chk("flush_valid", {31'd0, EX_VALID}, 32'd0);
    chk("flush_reg_we", {31'd0, EX_REG_WE}, 32'd0);
    chk("flush_mem_we", {31'd0, EX_MEM_WE}, 32'd0);
    FLUSH = 0; STALL = 0;

    // Operand selects
    clear_id();
    ID_VALID = 1; ID_PC = 32'h40; ID_SRCA_SEL = 2'd1; ID_SRCB_SEL = 2'd2;
    step();
    chk("sel_a_pc", ALU_SRC_A, 32'h40);
    chk("sel_b_four", ALU_SRC_B, 32'd4);
    ID_SRCA_SEL = 2'd2; ID_IMM = 32'h12345000; ID_ALU_FUN = ALU_LUI;
    step();
    chk("sel_a_imm", ALU_SRC_A, 32'h12345000);
    chk("sel_lui_fun", {28'd0, ALU_FUN}, {28'd0, ALU_LUI});
    ID_SRCA_SEL = 2'd3; ID_SRCB_SEL = 2'd3;
    ID_RS1_ADDR = 5'd11; ID_RS1_DATA = 32'hFFFF; ID_RS2_ADDR = 5'd12; ID_RS2_DATA = 32'hEEEE;
    step();
    chk("sel_a_zero", ALU_SRC_A, 32'd0);
    chk("sel_b_zero", ALU_SRC_B, 32'd0);
    chk("sel_store_rs2", EX_STORE_DATA, 32'hEEEE);

    // Invalid decode captures a bubble
    ID_VALID = 0;
    step();
    chk("invalid_bubble", {31'd0, EX_VALID}, 32'd0);
    chk("invalid_fun", {28'd0, ALU_FUN}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
